// File: rtl/instr_fetch.sv
// Instruction fetch: reads a two-word instruction (op, operand) for pc from ROM over req/ack.
// Latency: instr_valid rises 3 cycles after fetch start with zero-wait ROM; 1 instruction / 3 cycles back-to-back.
// Backpressure: holds the instruction while instr_ready is low; ROM requests wait for ack and are never abandoned.
module instr_fetch #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  flush,
    output logic                  rom_req,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic                  rom_ack,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] op,
    output logic [DATA_WIDTH-1:0] operand,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP,
        S_OPND,
        S_VALID,
        S_DRAIN
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [DATA_WIDTH-1:0] fetch_pc;
    logic [DATA_WIDTH-1:0] fetch_pc_nxt;
    logic [DATA_WIDTH-1:0] op_reg;
    logic [DATA_WIDTH-1:0] op_nxt;
    logic [DATA_WIDTH-1:0] operand_reg;
    logic [DATA_WIDTH-1:0] operand_nxt;
    logic                  rom_req_nxt;
    logic [ADDR_WIDTH-1:0] rom_addr_nxt;
    logic                  valid_nxt;

    // An ack only completes a transaction while a request is actually outstanding.
    logic                  ack;
    assign ack = rom_ack & rom_req;

    // Word addresses of the instruction slots; the pc MSB falls off so addresses wrap.
    logic [ADDR_WIDTH-1:0] pc_op_addr;
    logic [ADDR_WIDTH-1:0] fetch_opnd_addr;
    assign pc_op_addr      = {pc[ADDR_WIDTH-2:0], 1'b0};
    assign fetch_opnd_addr = {fetch_pc[ADDR_WIDTH-2:0], 1'b1};

    // The discarded pc MSB is intentionally never used for addressing.
    logic                  unused_fetch_pc_msb;
    assign unused_fetch_pc_msb = ^fetch_pc[DATA_WIDTH-1:ADDR_WIDTH-1];

    // Next-state and next-register values; every target holds unless a transition updates it.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        rom_req_nxt  = rom_req;
        rom_addr_nxt = rom_addr;
        valid_nxt    = instr_valid;
        op_nxt       = op_reg;
        operand_nxt  = operand_reg;

        case (state)
            S_IDLE: begin
                // Fetch start: pc is sampled here and nowhere else except on accept.
                fetch_pc_nxt = pc;
                rom_req_nxt  = 1'b1;
                rom_addr_nxt = pc_op_addr;
                state_nxt    = S_OP;
            end
            S_OP: begin
                if (ack) begin
                    if (flush) begin
                        rom_req_nxt = 1'b0;
                        state_nxt   = S_IDLE;
                    end else begin
                        op_nxt       = rom_data;
                        rom_addr_nxt = fetch_opnd_addr;
                        state_nxt    = S_OPND;
                    end
                end else if (flush) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_OPND: begin
                if (ack) begin
                    rom_req_nxt = 1'b0;
                    if (flush) begin
                        state_nxt = S_IDLE;
                    end else begin
                        operand_nxt = rom_data;
                        valid_nxt   = 1'b1;
                        state_nxt   = S_VALID;
                    end
                end else if (flush) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_VALID: begin
                if (flush) begin
                    // Flush beats a simultaneous ready: the instruction is dropped, not accepted.
                    valid_nxt = 1'b0;
                    state_nxt = S_IDLE;
                end else if (instr_ready) begin
                    // Accept and immediately issue the next op read, skipping S_IDLE.
                    valid_nxt    = 1'b0;
                    fetch_pc_nxt = pc;
                    rom_req_nxt  = 1'b1;
                    rom_addr_nxt = pc_op_addr;
                    state_nxt    = S_OP;
                end
            end
            S_DRAIN: begin
                // Keep the abandoned request alive until the ROM answers, then drop the data.
                if (ack) begin
                    rom_req_nxt = 1'b0;
                    state_nxt   = S_IDLE;
                end
            end
            default: begin
                state_nxt   = S_IDLE;
                rom_req_nxt = 1'b0;
                valid_nxt   = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            fetch_pc    <= '0;
            rom_req     <= 1'b0;
            rom_addr    <= '0;
            instr_valid <= 1'b0;
            op_reg      <= '0;
            operand_reg <= '0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            rom_req     <= rom_req_nxt;
            rom_addr    <= rom_addr_nxt;
            instr_valid <= valid_nxt;
            op_reg      <= op_nxt;
            operand_reg <= operand_nxt;
        end
    end

    // Consumers see a NOP whenever no complete instruction is held.
    assign op      = instr_valid ? op_reg : '0;
    assign operand = instr_valid ? operand_reg : '0;
    assign busy    = rom_req;

endmodule
